// File: rtl/pwm_pkg.sv
// Shared register map and CTRL bit positions for the multichannel PWM peripheral.
package pwm_pkg;

    localparam logic [31:0] OFF_CTRL     = 32'h00;
    localparam logic [31:0] OFF_PERIOD   = 32'h08;
    localparam logic [31:0] OFF_PRESCALE = 32'h10;
    localparam logic [31:0] OFF_COUNT    = 32'h18;
    localparam logic [31:0] OFF_DUTY0    = 32'h20;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int CTRL_IRQF    = 3;
    localparam int CTRL_INV_LSB = 8;

    // Byte offset of the DUTY register belonging to channel ch.
    function automatic logic [31:0] duty_offset(input int ch);
        return OFF_DUTY0 + (32'(ch) << 3);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaled timebase: edge-aligned sawtooth or center-aligned triangle counter.
module pwm_timebase #(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] period,
    input  logic [N-1:0] prescale,
    output logic [N-1:0] count,
    output logic         boundary
);

    logic [N-1:0] pcnt;
    logic         down;
    logic         tick;

    assign tick = en && (pcnt == prescale);

    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (!mode)
                boundary = (count == period);
            else if (period == '0)
                boundary = 1'b1;
            else
                boundary = down && (count == '0);
        end
    end

    // A disabled timebase parks at zero counting up, so enabling always restarts cleanly.
    always_ff @(posedge clock) begin
        if (reset || !en) begin
            pcnt  <= '0;
            count <= '0;
            down  <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                if (!mode) begin
                    down  <= 1'b0;
                    count <= (count == period) ? '0 : count + 1'b1;
                end else if (period == '0) begin
                    down  <= 1'b0;
                    count <= '0;
                end else if (!down) begin
                    if (count == period) begin
                        down  <= 1'b1;
                        count <= count - 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    if (count == '0) begin
                        down  <= 1'b0;
                        count <= count + 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Memory-mapped multichannel PWM: address decode, double-buffered registers,
// compare array and period interrupt around a shared timebase.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter logic [31:0] base_address  = 32'h9000_0000,
    parameter int          address_width = 8,
    parameter int          N             = 64,
    parameter int          CHANNELS      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         address,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [N-1:0]        write_data,
    output logic [N-1:0]        read_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);

    localparam logic [31:0] DECODE_MASK = 32'hFFFF_FFFF << address_width;

    logic                cs;
    logic [31:0]         off;
    logic                hit_ctrl;
    logic                hit_period;
    logic                hit_prescale;
    logic                hit_count;
    logic [CHANNELS-1:0] hit_duty;
    logic                wr;

    logic                en;
    logic                mode;
    logic                irq_en;
    logic                irq_flag;
    logic [CHANNELS-1:0] inv;

    logic [N-1:0]        period_sh;
    logic [N-1:0]        prescale_sh;
    logic [N-1:0]        duty_sh  [CHANNELS];
    logic [N-1:0]        period_act;
    logic [N-1:0]        prescale_act;
    logic [N-1:0]        duty_act [CHANNELS];

    logic [N-1:0]        count;
    logic                boundary;
    logic [CHANNELS-1:0] pwm_p1;

    always_comb begin
        cs           = (address & DECODE_MASK) == base_address;
        off          = 32'(address[address_width-1:0]) & ~32'h7;
        hit_ctrl     = cs && (off == OFF_CTRL);
        hit_period   = cs && (off == OFF_PERIOD);
        hit_prescale = cs && (off == OFF_PRESCALE);
        hit_count    = cs && (off == OFF_COUNT);
        for (int i = 0; i < CHANNELS; i++)
            hit_duty[i] = cs && (off == duty_offset(i));
        wr           = mem_write;
    end

    pwm_timebase #(
        .N(N)
    ) u_timebase (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .period   (period_act),
        .prescale (prescale_act),
        .count    (count),
        .boundary (boundary)
    );

    // A boundary setting IRQ_FLAG outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            en       <= 1'b0;
            mode     <= 1'b0;
            irq_en   <= 1'b0;
            irq_flag <= 1'b0;
            inv      <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && hit_ctrl) begin
                en     <= write_data[CTRL_EN];
                mode   <= write_data[CTRL_MODE];
                irq_en <= write_data[CTRL_IRQEN];
                inv    <= write_data[CTRL_INV_LSB +: CHANNELS];
            end
            if (boundary)
                irq_flag <= 1'b1;
            else if (wr && hit_ctrl && write_data[CTRL_IRQF])
                irq_flag <= 1'b0;
            irq <= irq_flag && irq_en;
        end
    end

    // Shadows take bus writes; active copies follow them at each boundary or while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_sh    <= '0;
            prescale_sh  <= '0;
            period_act   <= '0;
            prescale_act <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (wr && hit_period)
                period_sh <= write_data;
            if (wr && hit_prescale)
                prescale_sh <= write_data;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr && hit_duty[i])
                    duty_sh[i] <= write_data;
            end
            if (!en || boundary) begin
                period_act   <= period_sh;
                prescale_act <= prescale_sh;
                for (int i = 0; i < CHANNELS; i++)
                    duty_act[i] <= duty_sh[i];
            end
        end
    end

    // Stage p1: registered compare, one clock behind the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_p1 <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                pwm_p1[i] <= en ? ((count < duty_act[i]) ^ inv[i]) : inv[i];
        end
    end

    assign pwm_out = pwm_p1;

    always_comb begin
        read_data = '0;
        if (cs && mem_read) begin
            if (hit_ctrl) begin
                read_data[CTRL_EN]                      = en;
                read_data[CTRL_MODE]                    = mode;
                read_data[CTRL_IRQEN]                   = irq_en;
                read_data[CTRL_IRQF]                    = irq_flag;
                read_data[CTRL_INV_LSB +: CHANNELS]     = inv;
            end
            if (hit_period)
                read_data = period_sh;
            if (hit_prescale)
                read_data = prescale_sh;
            if (hit_count)
                read_data = count;
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit_duty[i])
                    read_data = duty_sh[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: register table plus waveform sequences.
module tb_pwm_multichannel;
    import pwm_pkg::*;

    localparam logic [31:0] B = 32'h9000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] write_data = '0;
    logic [63:0] read_data;
    logic [3:0]  pwm_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    string       name_q[$];
    logic [63:0] val_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [63:0] wdata;
        logic [31:0] raddr;
        logic [63:0] exp;
    } reg_vec_t;

    reg_vec_t vec[17];

    pwm_multichannel #(
        .base_address  (B),
        .address_width (8),
        .N             (64),
        .CHANNELS      (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .read_data  (read_data),
        .pwm_out    (pwm_out),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string n, input logic [63:0] v);
        name_q.push_back(n);
        val_q.push_back(v);
    endtask

    task automatic compare_next(input logic [63:0] act);
        string       n;
        logic [63:0] v;
        checks++;
        if (val_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0h required an expectation", act);
        end else begin
            n = name_q.pop_front();
            v = val_q.pop_front();
            if (act !== v) begin
                errors++;
                $display("FAIL %s: got %0h required %0h", n, act, v);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [63:0] d);
        @(negedge clock);
        address    = a;
        write_data = d;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        @(posedge clock);
        #1;
        mem_write  = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [63:0] d);
        address  = a;
        mem_read = 1'b1;
        #1;
        d        = read_data;
        mem_read = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic int tri_cnt(input int j);
        int m;
        m = j % 8;
        return (m <= 4) ? m : 8 - m;
    endfunction

    function automatic logic [63:0] b64(input bit x);
        return {63'b0, x};
    endfunction

    initial begin
        logic [63:0] rd;
        int          irq_exp [11];
        int          flag_exp[11];

        irq_exp  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        flag_exp = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1};

        vec[0]  = '{1'b0, 32'h0, 64'h0, B + OFF_CTRL,      64'h0};
        vec[1]  = '{1'b0, 32'h0, 64'h0, B + OFF_PERIOD,    64'h0};
        vec[2]  = '{1'b0, 32'h0, 64'h0, B + OFF_PRESCALE,  64'h0};
        vec[3]  = '{1'b0, 32'h0, 64'h0, B + OFF_COUNT,     64'h0};
        vec[4]  = '{1'b0, 32'h0, 64'h0, B + 32'h20,        64'h0};
        vec[5]  = '{1'b0, 32'h0, 64'h0, B + 32'h28,        64'h0};
        vec[6]  = '{1'b0, 32'h0, 64'h0, B + 32'h30,        64'h0};
        vec[7]  = '{1'b0, 32'h0, 64'h0, B + 32'h38,        64'h0};
        vec[8]  = '{1'b1, B + OFF_PERIOD, 64'h1234_5678_9ABC_DEF0, B + OFF_PERIOD, 64'h1234_5678_9ABC_DEF0};
        vec[9]  = '{1'b1, B + OFF_PRESCALE, 64'hA5, B + OFF_PRESCALE, 64'hA5};
        vec[10] = '{1'b1, B + 32'h38, 64'h55, B + 32'h3C, 64'h55};
        vec[11] = '{1'b1, B + 32'h40, 64'hDEAD, B + 32'h40, 64'h0};
        vec[12] = '{1'b1, B + OFF_COUNT, 64'h5, B + OFF_COUNT, 64'h0};
        vec[13] = '{1'b1, 32'h9000_0108, 64'h7, B + 32'h0B, 64'h1234_5678_9ABC_DEF0};
        vec[14] = '{1'b1, B + OFF_CTRL, 64'hFFFF_FFFF_FFFF_FFF6, B + OFF_CTRL, 64'hF06};
        vec[15] = '{1'b1, B + 32'h28, 64'h77, 32'h8000_0028, 64'h0};
        vec[16] = '{1'b1, B + 32'h20, 64'h11, B + 32'h20, 64'h11};

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        expect_val("reset_pwm", 64'h0);
        expect_val("reset_irq", 64'h0);
        compare_next({60'b0, pwm_out});
        compare_next(b64(irq));

        for (int i = 0; i < 17; i++) begin
            expect_val($sformatf("reg_vec%0d", i), vec[i].exp);
            if (vec[i].wr)
                bus_write(vec[i].waddr, vec[i].wdata);
            read_reg(vec[i].raddr, rd);
            compare_next(rd);
        end
        expect_val("idle_inv_level", 64'hF);
        step();
        compare_next({60'b0, pwm_out});

        // Edge-aligned: PERIOD 9, DUTY0 3.
        do_reset();
        bus_write(B + OFF_PERIOD, 64'd9);
        bus_write(B + 32'h20, 64'd3);
        bus_write(B + OFF_CTRL, 64'h1);
        for (int k = 0; k < 25; k++) begin
            expect_val("edge_pwm", b64(k > 0 && ((k - 1) % 10) < 3));
            expect_val("edge_count", 64'(k % 10));
            if (k > 0)
                step();
            compare_next({60'b0, pwm_out});
            read_reg(B + OFF_COUNT, rd);
            compare_next(rd);
        end

        // Center-aligned: PERIOD 4, DUTY1 2, INV1 set.
        do_reset();
        bus_write(B + OFF_PERIOD, 64'd4);
        bus_write(B + 32'h28, 64'd2);
        bus_write(B + OFF_CTRL, 64'h203);
        for (int k = 0; k < 21; k++) begin
            expect_val("center_pwm", {62'b0, (k > 0 && tri_cnt(k - 1) >= 2), 1'b0});
            expect_val("center_count", 64'(tri_cnt(k)));
            if (k > 0)
                step();
            compare_next({60'b0, pwm_out});
            read_reg(B + OFF_COUNT, rd);
            compare_next(rd);
        end

        // Double buffer: DUTY0 3 -> 7 written mid-period.
        do_reset();
        bus_write(B + OFF_PERIOD, 64'd9);
        bus_write(B + 32'h20, 64'd3);
        bus_write(B + OFF_CTRL, 64'h1);
        for (int k = 0; k < 25; k++) begin
            expect_val("dbuf_pwm", b64(k > 0 && ((k - 1) % 10) < (((k - 1) / 10 == 0) ? 3 : 7)));
            if (k == 6) begin
                bus_write(B + 32'h20, 64'd7);
                expect_val("dbuf_shadow_read", 64'd7);
            end else if (k > 0) begin
                step();
            end
            compare_next({60'b0, pwm_out});
            if (k == 6) begin
                read_reg(B + 32'h20, rd);
                compare_next(rd);
            end
        end

        // PRESCALE 2 with DUTY0 beyond PERIOD: slow count, output always active.
        do_reset();
        bus_write(B + OFF_PERIOD, 64'd9);
        bus_write(B + OFF_PRESCALE, 64'd2);
        bus_write(B + 32'h20, 64'd10);
        bus_write(B + OFF_CTRL, 64'h1);
        for (int k = 0; k < 31; k++) begin
            expect_val("presc_pwm", b64(k > 0));
            expect_val("presc_count", 64'((k / 3) % 10));
            if (k > 0)
                step();
            compare_next({60'b0, pwm_out});
            read_reg(B + OFF_COUNT, rd);
            compare_next(rd);
        end

        // IRQ: PERIOD 3, clear off-boundary, then clear on a boundary.
        do_reset();
        bus_write(B + OFF_PERIOD, 64'd3);
        bus_write(B + OFF_CTRL, 64'h105);
        for (int k = 1; k < 11; k++) begin
            expect_val("irq_line", 64'(irq_exp[k]));
            expect_val("irq_ctrl_read", flag_exp[k] != 0 ? 64'h10D : 64'h105);
            expect_val("irq_pwm_inv", 64'h1);
            if (k == 6 || k == 8)
                bus_write(B + OFF_CTRL, 64'h10D);
            else
                step();
            compare_next(b64(irq));
            read_reg(B + OFF_CTRL, rd);
            compare_next(rd);
            compare_next({60'b0, pwm_out});
        end

        // Synchronous reset mid-period.
        @(negedge clock);
        reset = 1'b1;
        expect_val("midreset_pwm", 64'h0);
        expect_val("midreset_irq", 64'h0);
        expect_val("midreset_count", 64'h0);
        expect_val("midreset_ctrl", 64'h0);
        step();
        compare_next({60'b0, pwm_out});
        compare_next(b64(irq));
        read_reg(B + OFF_COUNT, rd);
        compare_next(rd);
        read_reg(B + OFF_CTRL, rd);
        compare_next(rd);
        @(negedge clock);
        reset = 1'b0;

        if (val_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending required 0", val_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
